bus_arbiter_8_way_16: RTL
=========================

# bus_arbiter_8_way_16

Round-robin arbiter that shares one 16-bit output channel among eight requesters. Each requester presents a 16-bit word and a request bit. The block picks one requester fairly and latches its word through an 8-way, 16-bit mux. It then holds the word on a valid/ready channel until the consumer accepts it, and pulses a per-requester acknowledge. It sits between the emulator's memory-mapped peripheral sources and the single shared write port of the CPU-side bus.

## Interface
Parameters: none. Widths are fixed at 8 ways × 16 bits and are held as constants in the package.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  8  request bits; `req[i]` high means requester i has a word pending.
- in  in  128  packed requester data; word i is `in[i*16 +: 16]`.
- out_ready  in  1  consumer can accept `out_data` this cycle.
- out_valid  out  1  `out_data` holds a granted word.
- out_data  out  16  latched word of the granted requester.
- grant_idx  out  3  index of the current or most recent grant.
- ack  out  8  one-hot, one-cycle pulse on the cycle requester i's word is accepted.
- busy  out  1  high while in GNT, identical to `out_valid`.

## Operation
- States are IDLE and GNT.
- IDLE:
  - If `req` is zero, stay in IDLE.
  - Otherwise pick the first set bit of `req`, scanning from `last+1` upward with wrap modulo 8.
  - Latch that index into `grant_idx`.
  - Latch `in[idx*16 +: 16]` into `out_data`.
  - Go to GNT.
- GNT:
  - `out_valid` is 1.
  - `out_data` and `grant_idx` are frozen. Changes to `req` or `in` are ignored, including the granted requester dropping its req.
- Handshake: a word is accepted when `out_valid && out_ready` is true at a rising edge.
  - Assert `ack[grant_idx]` combinationally in that same cycle.
  - At the edge, set `last <= grant_idx` and go to IDLE.
- Requesters must deassert req on the cycle after their ack, or they will be considered again in the next arbitration.
- Fairness: the winner becomes lowest priority. Each continuously requesting index is served within 8 grants.
- Arithmetic: the pointer is 3-bit unsigned, so `last+1` wraps from 7 to 0. The scan covers all 8 positions, including `last` itself, which is examined last.

## Timing
- Reset: at a rising edge with `reset` high, all outputs and state take their reset values.
  - State goes to IDLE.
  - `out_valid=0`, `busy=0`, `out_data=16'h0000`, `grant_idx=0`, `ack=0`.
  - `last=7`, so requester 0 has the highest priority after reset.
  - Reset takes precedence over a handshake in the same cycle: no ack is issued and the pending word is dropped.
- Grant latency: req sampled in IDLE at edge N gives `out_valid=1` from edge N, visible during cycle N+1.
- Accept: the handshake at edge M gives `out_valid=0` after M. The earliest next `out_valid` is after edge M+1.
- Throughput is one word every 2 cycles. The single bubble is intentional.
- `out_ready` may be high while `out_valid` is low. This has no effect.
- `out_ready` low in GNT: hold the word indefinitely with no timeout.
- `ack` is never registered and is zero whenever no handshake occurs.

## Structure
- Package `bus_arbiter_pkg` holds:
  - `WAYS=8`, `WIDTH=16`, `SEL_BITS=3`;
  - enum `arb_state_t {IDLE, GNT}`.
- Instantiate existing `mux_8_way_16` (ports `in`, `sel`, `out`) to select the candidate word.
  - Drive `sel` from the combinational round-robin pick.
  - The mux output feeds the `out_data` register enable path.
- Round-robin pick logic stays in the top module as one combinational block: rotate `req` by `last+1`, take a priority encode, un-rotate. No further sub-modules.

## Test plan
- Reset then single request:
  - Stimulus: `req=8'b0000_0100`, word 2 = `16'hBEEF`, `out_ready=1`.
  - Required: `out_valid` high one cycle later with `out_data=16'hBEEF`, `grant_idx=2`; `ack=8'b0000_0100` for exactly one cycle.
- Round-robin order:
  - Stimulus: `req=8'hFF` held, `out_ready=1`.
  - Required: grants 0,1,2,…,7,0, each a distinct latched word, one every 2 cycles.
- Wrap-around:
  - Stimulus: after a grant to 7, `req=8'b1000_0001`.
  - Required: next grant is 0, then 7.
- Backpressure:
  - Stimulus: `out_ready=0` for 10 cycles while `in` and `req` are randomized.
  - Required: `out_data` and `grant_idx` are constant and `ack=0`. Raise `out_ready`: ack occurs in that cycle.
- Reset mid-GNT:
  - Stimulus: assert reset together with `out_ready` during GNT.
  - Required: no ack; next cycle `out_valid=0`, `out_data=0`, `grant_idx=0`; requester 0 wins the next arbitration.
- Random regression:
  - Stimulus: 128 iterations of random `req`, `in` and `out_ready`.
  - Required: a scoreboard checks `out_data == in[grant*16+:16]` at grant time, checks the round-robin order, and `$fatal` on mismatch.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared widths, FSM state type and helpers for the 8-way arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

    localparam int WAYS     = 8;
    localparam int WIDTH    = 16;
    localparam int SEL_BITS = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GNT  = 1'b1
    } arb_state_t;

    function automatic logic [WAYS-1:0] idx_to_onehot(input logic [SEL_BITS-1:0] idx);
        logic [WAYS-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/mux_8_way_16.sv
`default_nettype none
// ============================================================================
// Module      : mux_8_way_16
// Description : 8-way, 16-bit word selector over a packed 128-bit bus.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_8_way_16 (
    input  logic [127:0] in,
    input  logic [2:0]   sel,
    output logic [15:0]  out
);

    // Word offset built by concatenation so the index keeps its full 7 bits.
    assign out = in[{sel, 4'b0000} +: 16];

endmodule : mux_8_way_16
`default_nettype wire

// File: rtl/bus_arbiter_8_way_16.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_8_way_16
// Description : Round-robin 8-way arbiter driving one 16-bit valid/ready channel.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_8_way_16
    import bus_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WAYS-1:0]        req,
    input  logic [WAYS*WIDTH-1:0]  in,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_BITS-1:0]    grant_idx,
    output logic [WAYS-1:0]        ack,
    output logic                   busy
);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic [SEL_BITS-1:0]   r_last;
    logic [SEL_BITS-1:0]   r_grant_idx;
    logic [WIDTH-1:0]      r_out_data;

    logic [SEL_BITS-1:0]   w_start;
    logic [2*WAYS-1:0]     w_dbl;
    logic [WAYS-1:0]       w_rot;
    logic [SEL_BITS-1:0]   w_off;
    logic [SEL_BITS-1:0]   w_pick;
    logic [WIDTH-1:0]      w_mux_out;
    logic                  w_load;
    logic                  w_accept;

    // Rotate so position last+1 sits at bit 0, find the lowest set bit,
    // then add the rotation back; the 3-bit sum wraps modulo 8.
    always_comb begin
        w_start = r_last + 3'd1;
        w_dbl   = {req, req} >> w_start;
        w_rot   = w_dbl[WAYS-1:0];
        w_off   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SEL_BITS'(i);
            end
        end
        w_pick = w_start + w_off;
    end

    mux_8_way_16 u_mux (
        .in  (in),
        .sel (w_pick),
        .out (w_mux_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_load       = 1'b1;
                    w_next_state = GNT;
                end
            end
            GNT: begin
                if (out_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last      <= 3'd7;
            r_grant_idx <= '0;
            r_out_data  <= '0;
        end else begin
            if (w_load) begin
                r_grant_idx <= w_pick;
                r_out_data  <= w_mux_out;
            end
            if (w_accept) begin
                r_last <= r_grant_idx;
            end
        end
    end

    // A reset in the handshake cycle drops the word, so no ack escapes.
    assign ack       = (w_accept && !reset) ? idx_to_onehot(r_grant_idx) : '0;
    assign out_valid = (r_state == GNT);
    assign busy      = (r_state == GNT);
    assign out_data  = r_out_data;
    assign grant_idx = r_grant_idx;

endmodule : bus_arbiter_8_way_16
`default_nettype wire
